piso_bit_feeder: RTL and testbench

- Upstream stage of the serial sequence detectors.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, MSB first.
- Serial outputs: x (data bit), x_valid (bit qualifier), last_bit (final bit of a frame).
- Supports optional inter-word idle gaps, so detector benches and datapaths get a deterministic bit stream from word-level sources.

---
 rtl/piso_bit_feeder.sv | 155 +++++++++++++++
 tb/tb_piso_bit_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_feeder.sv
// Parallel-in, serial-out bit feeder: accepts words over valid/ready and emits them MSB first.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_bit_feeder #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int                CNT_W    = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME - 1);
    localparam bit                HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0]        GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("piso_bit_feeder: WIDTH must be in 2..32");
        end
        if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
            $error("piso_bit_feeder: GAP_CYCLES must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [FRAME-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               last_bit_q, last_bit_d;
    logic               busy_q, busy_d;

    logic [FRAME-1:0]   load_word;
    logic               at_last;
    logic               handshake;

`ifdef PISO_PARITY_EN
    assign load_word = {din, ^din};
`else
    assign load_word = din;
`endif

    assign at_last   = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT);
    // Back-to-back acceptance is only possible when no gap has to follow the frame.
    assign din_ready = rst && ((state_q == ST_IDLE) || (at_last && !HAS_GAP));
    assign handshake = din_valid && din_ready;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        busy_d     = busy_q;
        x_d        = IDLE_BIT;
        x_valid_d  = 1'b0;
        last_bit_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_SHIFT: begin
                if (at_last) begin
                    if (HAS_GAP) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 4'd0;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    x_d        = shreg_q[FRAME-1];
                    shreg_d    = shreg_q << 1;
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    x_valid_d  = 1'b1;
                    last_bit_d = (bit_cnt_d == LAST_CNT);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A handshake (IDLE or last-bit cycle) overrides the frame-end decision above.
        if (handshake) begin
            state_d    = ST_SHIFT;
            x_d        = load_word[FRAME-1];
            shreg_d    = load_word << 1;
            bit_cnt_d  = '0;
            x_valid_d  = 1'b1;
            last_bit_d = 1'b0;
            busy_d     = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            x_q        <= IDLE_BIT;
            x_valid_q  <= 1'b0;
            last_bit_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            x_q        <= x_d;
            x_valid_q  <= x_valid_d;
            last_bit_q <= last_bit_d;
            busy_q     <= busy_d;
        end
    end

    assign x        = x_q;
    assign x_valid  = x_valid_q;
    assign last_bit = last_bit_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Self-checking bench for piso_bit_feeder: scoreboard of expected serial bits per accepted word,
// plus directed checks of handshake timing, gap insertion and asynchronous reset.
module tb_piso_bit_feeder;

    localparam int   WIDTH    = 8;
    localparam logic IDLE_BIT = 1'b0;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [WIDTH-1:0] din = '0;
    logic din_valid = 1'b0;
    logic din_ready, x, x_valid, last_bit, busy;

    logic [WIDTH-1:0] g_din = '0;
    logic g_din_valid = 1'b0;
    logic g_din_ready, g_x, g_x_valid, g_last_bit, g_busy;

    exp_t q[$];
    exp_t gq[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_bit_feeder #(.WIDTH(WIDTH), .GAP_CYCLES(0), .IDLE_BIT(IDLE_BIT)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .x(x), .x_valid(x_valid), .last_bit(last_bit), .busy(busy)
    );

    piso_bit_feeder #(.WIDTH(WIDTH), .GAP_CYCLES(2), .IDLE_BIT(IDLE_BIT)) dut_gap (
        .clk(clk), .rst(rst), .din(g_din), .din_valid(g_din_valid), .din_ready(g_din_ready),
        .x(g_x), .x_valid(g_x_valid), .last_bit(g_last_bit), .busy(g_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef PISO_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the no-gap instance; outputs sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (x_valid) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("x_bit", x, e.b);
                    check("last_bit", last_bit, e.last);
                end
            end else begin
                check("idle_x", x, IDLE_BIT);
                check("idle_last", last_bit, 1'b0);
            end
            if (din_valid && din_ready) begin
                logic [FRAME-1:0] f;
                f = frame_of(din);
                for (int i = FRAME - 1; i >= 0; i--) q.push_back('{b: f[i], last: (i == 0)});
            end
        end
    end

    // Scoreboard monitor for the gap instance.
    always @(negedge clk) begin
        if (rst) begin
            if (g_x_valid) begin
                if (gq.size() == 0) begin
                    check("g_sb_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = gq.pop_front();
                    check("g_x_bit", g_x, e.b);
                    check("g_last_bit", g_last_bit, e.last);
                end
            end else begin
                check("g_idle_x", g_x, IDLE_BIT);
                check("g_idle_last", g_last_bit, 1'b0);
            end
            if (g_din_valid && g_din_ready) begin
                logic [FRAME-1:0] f;
                f = frame_of(g_din);
                for (int i = FRAME - 1; i >= 0; i--) gq.push_back('{b: f[i], last: (i == 0)});
            end
        end
    end

    initial begin
        // Reset state
        #1;
        check("rst_din_ready", din_ready, 1'b0);
        check("rst_x_valid", x_valid, 1'b0);
        check("rst_x", x, IDLE_BIT);
        check("rst_last", last_bit, 1'b0);
        check("rst_busy", busy, 1'b0);
        step(2);
        rst = 1'b1;
        #1;
        check("idle_din_ready", din_ready, 1'b1);
        check("g_idle_din_ready", g_din_ready, 1'b1);

        // Basic frame 8'hA5
        din = 8'hA5;
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        check("basic_busy", busy, 1'b1);
        check("basic_ready_mid", din_ready, 1'b0);
        check("basic_first_valid", x_valid, 1'b1);
        step(FRAME);
        check("basic_end_valid", x_valid, 1'b0);
        check("basic_end_busy", busy, 1'b0);
        check("basic_end_ready", din_ready, 1'b1);

        // Back-to-back 8'hA5 then 8'h5A with continuous x_valid
        din = 8'hA5;
        din_valid = 1'b1;
        step(1);
        din = 8'h5A;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == FRAME) din_valid = 1'b0;
            check($sformatf("b2b_valid_%0d", i), x_valid, 1'b1);
            check($sformatf("b2b_ready_%0d", i), din_ready,
                  (i == FRAME - 1 || i == 2 * FRAME - 1) ? 1'b1 : 1'b0);
            step(1);
        end
        check("b2b_end_valid", x_valid, 1'b0);
        check("b2b_end_busy", busy, 1'b0);

        // Stall/ignore: din changes mid-frame, new word taken at last-bit cycle
        din = 8'hFF;
        din_valid = 1'b1;
        step(1);
        din = 8'h00;
        step(FRAME);
        din_valid = 1'b0;
        check("stall_second_valid", x_valid, 1'b1);
        step(FRAME);
        check("stall_end_valid", x_valid, 1'b0);
        check("stall_end_busy", busy, 1'b0);

        // Asynchronous reset after 3 bits of 8'hA5
        din = 8'hA5;
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        step(2);
        #2;
        rst = 1'b0;
        q.delete();
        gq.delete();
        #1;
        check("arst_x_valid", x_valid, 1'b0);
        check("arst_last", last_bit, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_x", x, IDLE_BIT);
        check("arst_din_ready", din_ready, 1'b0);
        step(1);
        rst = 1'b1;
        #1;
        check("post_rst_ready", din_ready, 1'b1);
        check("post_rst_valid", x_valid, 1'b0);
        din = 8'h07;
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        step(FRAME);
        check("post_rst_end_valid", x_valid, 1'b0);

        // Gap insertion on the GAP_CYCLES=2 instance, second word queued
        g_din = 8'hA5;
        g_din_valid = 1'b1;
        step(1);
        g_din = 8'h5A;
        for (int i = 0; i < FRAME; i++) begin
            check($sformatf("gap_frame_valid_%0d", i), g_x_valid, 1'b1);
            check($sformatf("gap_frame_ready_%0d", i), g_din_ready, 1'b0);
            step(1);
        end
        for (int j = 0; j < 2; j++) begin
            check($sformatf("gap_idle_valid_%0d", j), g_x_valid, 1'b0);
            check($sformatf("gap_idle_ready_%0d", j), g_din_ready, 1'b0);
            check($sformatf("gap_idle_busy_%0d", j), g_busy, 1'b1);
            step(1);
        end
        check("gap_ready_back", g_din_ready, 1'b1);
        check("gap_busy_clear", g_busy, 1'b0);
        step(1);
        g_din_valid = 1'b0;
        check("gap_second_valid", g_x_valid, 1'b1);
        step(FRAME);
        check("gap_end_valid", g_x_valid, 1'b0);
        step(3);
        check("gap_end_busy", g_busy, 1'b0);

        check("sb_drained", q.size(), 0);
        check("g_sb_drained", gq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
